// File: rtl/scan_select.sv
// Channel scanner: selects one of CH data channels, either by a manual index or by an
// automatic round-robin scan that holds each channel for dwell+1 enabled cycles.
// All outputs are registered; out always reloads from the selected channel.
module scan_select #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 8,
  parameter int unsigned SELW  = 3,
  parameter int unsigned DWW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic                  mode,
  input  logic                  en,
  input  logic [SELW-1:0]       flag,
  input  logic [DWW-1:0]        dwell,
  output logic [WIDTH-1:0]      out,
  output logic [SELW-1:0]       sel_cur,
  output logic                  out_valid,
  output logic                  wrap,
  output logic                  err
);

  localparam int unsigned NumSlots = 2 ** SELW;
  // One extra bit so CH itself is representable when CH == 2**SELW.
  localparam logic [SELW:0]   ChLimit = (SELW + 1)'(CH);
  localparam logic [SELW-1:0] LastSel = SELW'(CH - 1);
  localparam logic [SELW-1:0] SelOne  = SELW'(1);
  localparam logic [DWW-1:0]  CntOne  = DWW'(1);

  logic [SELW-1:0]  sel_q, sel_d;
  logic [DWW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // Unused select codes (CH not a power of two) read as zero; they are never selected.
  logic [WIDTH-1:0] chan [NumSlots];

  for (genvar k = 0; k < NumSlots; k++) begin : g_chan
    if (k < CH) begin : g_used
      assign chan[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  // Next select, dwell counter and event pulses; out follows the next select.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (en) begin
      if (!mode) begin
        // Manual cycles always restart the dwell so a later auto scan begins with a full hold.
        cnt_d = '0;
        if ({1'b0, flag} < ChLimit) begin
          sel_d = flag;
        end else begin
          err_d = 1'b1;
        end
      end else if (cnt_q < dwell) begin
        cnt_d = cnt_q + CntOne;
      end else begin
        cnt_d = '0;
        if (sel_q == LastSel) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + SelOne;
        end
      end
    end
    out_d = chan[sel_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= 1'b1;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign sel_cur   = sel_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scan_select.sv
// Self-checking bench for scan_select: scoreboard of expected register values for an
// 8-channel instance, plus directed range/wrap checks on a 5-channel instance.
module tb_scan_select;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CH    = 8;
  localparam int unsigned SELW  = 3;
  localparam int unsigned DWW   = 16;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic [SELW-1:0]  sel;
    logic             valid;
    logic             wrap;
    logic             err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH*WIDTH-1:0] din = '0;
  logic                mode = 1'b0;
  logic                en = 1'b0;
  logic [SELW-1:0]     flag = '0;
  logic [DWW-1:0]      dwell = '0;
  logic [WIDTH-1:0]    out;
  logic [SELW-1:0]     sel_cur;
  logic                out_valid, wrap, err;

  logic                rst5 = 1'b1;
  logic [5*WIDTH-1:0]  din5 = '0;
  logic                mode5 = 1'b0;
  logic                en5 = 1'b0;
  logic [SELW-1:0]     flag5 = '0;
  logic [DWW-1:0]      dwell5 = '0;
  logic [WIDTH-1:0]    out5;
  logic [SELW-1:0]     sel5;
  logic                valid5, wrap5, err5;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Spec-level reference state for the 8-channel instance.
  int m_sel = 0;
  int m_cnt = 0;

  scan_select #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW), .DWW(DWW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .mode      (mode),
    .en        (en),
    .flag      (flag),
    .dwell     (dwell),
    .out       (out),
    .sel_cur   (sel_cur),
    .out_valid (out_valid),
    .wrap      (wrap),
    .err       (err)
  );

  scan_select #(.WIDTH(WIDTH), .CH(5), .SELW(SELW), .DWW(DWW)) u_dut5 (
    .clk       (clk),
    .rst       (rst5),
    .din       (din5),
    .mode      (mode5),
    .en        (en5),
    .flag      (flag5),
    .dwell     (dwell5),
    .out       (out5),
    .sel_cur   (sel5),
    .out_valid (valid5),
    .wrap      (wrap5),
    .err       (err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan_of(input int k);
    logic [CH*WIDTH-1:0] d;
    d = din;
    return d[k*WIDTH +: WIDTH];
  endfunction

  // Predict this edge from the current inputs, push, clock, then pop and compare.
  task automatic step();
    exp_t e;
    if (rst) begin
      m_sel = 0;
      m_cnt = 0;
      e = '0;
      e.out = '0;
    end else begin
      e = '0;
      e.valid = 1'b1;
      if (en) begin
        if (!mode) begin
          m_cnt = 0;
          if (int'(flag) < CH) m_sel = int'(flag);
          else e.err = 1'b1;
        end else if (m_cnt < int'(dwell)) begin
          m_cnt++;
        end else begin
          m_cnt = 0;
          e.wrap = (m_sel == CH - 1);
          m_sel = (m_sel == CH - 1) ? 0 : m_sel + 1;
        end
      end
      e.out = chan_of(m_sel);
    end
    e.sel = SELW'(m_sel);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("out", 32'(out), 32'(e.out));
    chk("sel_cur", 32'(sel_cur), 32'(e.sel));
    chk("out_valid", 32'(out_valid), 32'(e.valid));
    chk("wrap", 32'(wrap), 32'(e.wrap));
    chk("err", 32'(err), 32'(e.err));
    @(negedge clk);
  endtask

  task automatic tick5();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < CH; k++) din[k*WIDTH +: WIDTH] = WIDTH'(k + 3);
    for (int k = 0; k < 5; k++) din5[k*WIDTH +: WIDTH] = WIDTH'(k + 3);
    @(negedge clk);

    // Reset state
    step();
    step();

    // Manual sweep: out = flag + 3, sel_cur mirrors flag
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    for (int k = 0; k < CH; k++) begin
      flag = SELW'(k);
      step();
      chk("sweep_out", 32'(out), k + 3);
      chk("sweep_sel", 32'(sel_cur), k);
    end

    // Auto scan, dwell 2: three cycles per channel, wrap every 24
    reset_main();
    mode = 1'b1; dwell = 16'd2;
    for (int i = 1; i <= 50; i++) begin
      step();
      chk("scan_sel", 32'(sel_cur), (i / 3) % 8);
      chk("scan_wrap", 32'(wrap), (i % 24 == 0) ? 1 : 0);
    end

    // Enable freeze at channel 4 with dwell 0
    reset_main();
    dwell = '0;
    for (int i = 0; i < 4; i++) step();
    chk("freeze_start", 32'(sel_cur), 4);
    en = 1'b0;
    din[4*WIDTH +: WIDTH] = 4'hA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("freeze_sel", 32'(sel_cur), 4);
      chk("freeze_out", 32'(out), 32'hA);
    end
    en = 1'b1;
    step();
    chk("freeze_resume", 32'(sel_cur), 5);
    din[4*WIDTH +: WIDTH] = 4'h7;

    // Mid-scan reset at sel 5, cnt 2 with dwell 3
    reset_main();
    dwell = 16'd3;
    for (int i = 0; i < 22; i++) step();
    chk("pre_reset_sel", 32'(sel_cur), 5);
    rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("post_rst_sel", 32'(sel_cur), i / 4);
      chk("post_rst_valid", 32'(out_valid), 1);
    end

    // Mode switch: auto at 6 -> manual flag 1 -> auto dwell 1
    reset_main();
    dwell = '0;
    for (int i = 0; i < 6; i++) step();
    chk("ms_start", 32'(sel_cur), 6);
    mode = 1'b0; flag = 3'd1;
    step();
    chk("ms_manual", 32'(sel_cur), 1);
    mode = 1'b1; dwell = 16'd1; flag = 3'd7;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("ms_auto", 32'(sel_cur), 1 + i / 2);
    end

    // Dwell shortened below the running count steps on the next enabled cycle
    mode = 1'b0; flag = 3'd2;
    step();
    mode = 1'b1; dwell = 16'd5;
    for (int i = 0; i < 3; i++) step();
    dwell = 16'd1;
    step();
    chk("dwell_cut", 32'(sel_cur), 3);

    // Randomised traffic through the scoreboard
    for (int i = 0; i < 300; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = ($urandom_range(0, 2) != 0);
      flag  = SELW'($urandom_range(0, 7));
      dwell = DWW'($urandom_range(0, 3));
      din   = CH*WIDTH'($urandom);
      step();
    end

    // Five-channel instance: out-of-range manual flag and non-power-of-two wrap
    tick5();
    chk("ch5_rst_sel", 32'(sel5), 0);
    chk("ch5_rst_valid", 32'(valid5), 0);
    @(negedge clk);
    rst5 = 1'b0; en5 = 1'b1; mode5 = 1'b0; flag5 = 3'd2;
    tick5();
    chk("ch5_sel2", 32'(sel5), 2);
    chk("ch5_out2", 32'(out5), 5);
    chk("ch5_err_ok", 32'(err5), 0);
    @(negedge clk);
    flag5 = 3'd6;
    tick5();
    chk("ch5_reject_sel", 32'(sel5), 2);
    chk("ch5_reject_err", 32'(err5), 1);
    chk("ch5_reject_out", 32'(out5), 5);
    @(negedge clk);
    flag5 = 3'd4;
    tick5();
    chk("ch5_sel4", 32'(sel5), 4);
    chk("ch5_err_clear", 32'(err5), 0);
    chk("ch5_out4", 32'(out5), 7);
    @(negedge clk);
    flag5 = 3'd7; en5 = 1'b0;
    tick5();
    chk("ch5_dis_err", 32'(err5), 0);
    chk("ch5_dis_sel", 32'(sel5), 4);
    @(negedge clk);
    en5 = 1'b1; mode5 = 1'b1; dwell5 = '0;
    tick5();
    chk("ch5_wrap_sel", 32'(sel5), 0);
    chk("ch5_wrap", 32'(wrap5), 1);
    chk("ch5_wrap_out", 32'(out5), 3);
    @(negedge clk);
    tick5();
    chk("ch5_wrap_pulse", 32'(wrap5), 0);
    chk("ch5_step1", 32'(sel5), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
